vid_stream_out: RTL and testbench

- Pixel-clock-domain stage that sits directly upstream of the rgb2dvi encoder and replaces the raw video pins leaving the PS interface.
- Consumes an AXI4-Stream video stream (SOF on tuser, EOL on tlast) produced by the VDMA read channel.
- Generates the display timing internally and drives the vid_pData / VDE / HSync / VSync bundle.
- Locks the stream to frame start and resynchronises on underflow or framing errors. The display never tears mid-frame.

---
 rtl/vid_pkg.sv | 17 +
 rtl/vid_timing_gen.sv | 69 ++++++
 rtl/vid_stream_out.sv | 150 +++++++++++++++
 tb/tb_vid_stream_out.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared types and helpers for the pixel-clock video output stage.
package vid_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF,
    ARMED,
    RUN
  } state_t;

  typedef logic [23:0] pixel_t;

  // The stream carries {R,G,B}; rgb2dvi wants {R,B,G}.
  function automatic pixel_t rgb_to_rbg(input pixel_t p);
    return {p[23:16], p[7:0], p[15:8]};
  endfunction

endpackage

// File: rtl/vid_timing_gen.sv
// Free-running raster counters and the timing flags decoded from them.
// Flags are combinational; the consumer registers everything it drives out.
module vid_timing_gen #(
  parameter int unsigned H_ACTIVE      = 1280,
  parameter int unsigned H_FRONT_PORCH = 110,
  parameter int unsigned H_SYNC_WIDTH  = 40,
  parameter int unsigned H_BACK_PORCH  = 220,
  parameter int unsigned V_ACTIVE      = 720,
  parameter int unsigned V_FRONT_PORCH = 5,
  parameter int unsigned V_SYNC_WIDTH  = 5,
  parameter int unsigned V_BACK_PORCH  = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic active_o,
  output logic hs_o,
  output logic vs_o,
  output logic frame_first_o,
  output logic frame_last_o,
  output logic line_last_o
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT_PORCH;
  localparam int unsigned HS_END   = HS_START + H_SYNC_WIDTH;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT_PORCH;
  localparam int unsigned VS_END   = VS_START + V_SYNC_WIDTH;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  int unsigned   h_pos, v_pos;
  logic          h_wrap, v_wrap;

  assign h_pos  = {{(32-HW){1'b0}}, h_cnt_q};
  assign v_pos  = {{(32-VW){1'b0}}, v_cnt_q};
  assign h_wrap = (h_pos == H_TOTAL - 1);
  assign v_wrap = (v_pos == V_TOTAL - 1);

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      h_cnt_d = '0;
      v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // vs depends only on v_cnt, which only moves at the h wrap, so vsync edges land on h_cnt==0.
  assign active_o      = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
  assign hs_o          = (h_pos >= HS_START) && (h_pos < HS_END);
  assign vs_o          = (v_pos >= VS_START) && (v_pos < VS_END);
  assign frame_first_o = (h_pos == 0) && (v_pos == 0);
  assign frame_last_o  = h_wrap && v_wrap;
  assign line_last_o   = (h_pos == H_ACTIVE - 1);

endmodule

// File: rtl/vid_stream_out.sv
// AXI4-Stream video to rgb2dvi pixel bundle: internal timing, frame-locked
// stream consumption, and resynchronisation on underflow or framing errors.
module vid_stream_out
  import vid_pkg::*;
#(
  parameter int unsigned H_ACTIVE      = 1280,
  parameter int unsigned H_FRONT_PORCH = 110,
  parameter int unsigned H_SYNC_WIDTH  = 40,
  parameter int unsigned H_BACK_PORCH  = 220,
  parameter int unsigned V_ACTIVE      = 720,
  parameter int unsigned V_FRONT_PORCH = 5,
  parameter int unsigned V_SYNC_WIDTH  = 5,
  parameter int unsigned V_BACK_PORCH  = 20,
  parameter bit          HSYNC_POL     = 1'b1,
  parameter bit          VSYNC_POL     = 1'b1
) (
  input  logic        PixelClk,
  input  logic        vid_rstn,
  input  logic [23:0] s_axis_video_tdata,
  input  logic        s_axis_video_tvalid,
  output logic        s_axis_video_tready,
  input  logic        s_axis_video_tuser,
  input  logic        s_axis_video_tlast,
  output logic [23:0] vid_pData,
  output logic        vid_pVDE,
  output logic        vid_pHSync,
  output logic        vid_pVSync,
  output logic        locked,
  output logic        underflow,
  output logic        sync_err
);

  logic   active, hs, vs, frame_first, frame_last, line_last;
  state_t state_q, state_d;
  logic   sof_beat, user_err, last_err, starved, accept;
  pixel_t pdata_q, pdata_d;
  logic   vde_q, vde_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic   locked_q, locked_d, underflow_q, underflow_d, sync_err_q, sync_err_d;

  vid_timing_gen #(
    .H_ACTIVE     (H_ACTIVE),
    .H_FRONT_PORCH(H_FRONT_PORCH),
    .H_SYNC_WIDTH (H_SYNC_WIDTH),
    .H_BACK_PORCH (H_BACK_PORCH),
    .V_ACTIVE     (V_ACTIVE),
    .V_FRONT_PORCH(V_FRONT_PORCH),
    .V_SYNC_WIDTH (V_SYNC_WIDTH),
    .V_BACK_PORCH (V_BACK_PORCH)
  ) u_timing (
    .clk_i        (PixelClk),
    .rst_ni       (vid_rstn),
    .active_o     (active),
    .hs_o         (hs),
    .vs_o         (vs),
    .frame_first_o(frame_first),
    .frame_last_o (frame_last),
    .line_last_o  (line_last)
  );

  // Framing checks are only meaningful on active cycles while running.
  assign sof_beat = s_axis_video_tvalid && s_axis_video_tuser;
  assign starved  = active && !s_axis_video_tvalid;
  assign user_err = active && sof_beat && !frame_first;
  assign last_err = active && s_axis_video_tvalid && (s_axis_video_tlast != line_last);

  always_ff @(posedge PixelClk) begin
    if (!vid_rstn) begin
      state_q <= WAIT_SOF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_SOF: if (sof_beat) state_d = ARMED;
      ARMED:    if (frame_last) state_d = RUN;
      RUN:      if (starved || user_err || last_err) state_d = WAIT_SOF;
      default:  state_d = WAIT_SOF;
    endcase
  end

  // A misplaced SOF is left on the bus so the next WAIT_SOF can pick it up.
  always_comb begin
    accept      = 1'b0;
    pdata_d     = '0;
    vde_d       = active;
    locked_d    = 1'b0;
    underflow_d = 1'b0;
    sync_err_d  = 1'b0;
    unique case (state_q)
      WAIT_SOF: accept = active && !sof_beat;
      RUN: begin
        locked_d = 1'b1;
        if (active) begin
          if (starved) begin
            underflow_d = 1'b1;
            locked_d    = 1'b0;
          end else if (user_err) begin
            sync_err_d = 1'b1;
            locked_d   = 1'b0;
          end else if (last_err) begin
            sync_err_d = 1'b1;
            locked_d   = 1'b0;
            accept     = 1'b1;
          end else begin
            accept  = 1'b1;
            pdata_d = rgb_to_rbg(s_axis_video_tdata);
          end
        end
      end
      default: accept = 1'b0;
    endcase
  end

  assign hsync_d = hs ^ ~HSYNC_POL;
  assign vsync_d = vs ^ ~VSYNC_POL;

  always_ff @(posedge PixelClk) begin
    if (!vid_rstn) begin
      pdata_q     <= '0;
      vde_q       <= 1'b0;
      hsync_q     <= ~HSYNC_POL;
      vsync_q     <= ~VSYNC_POL;
      locked_q    <= 1'b0;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      pdata_q     <= pdata_d;
      vde_q       <= vde_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      locked_q    <= locked_d;
      underflow_q <= underflow_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // Gating with reset keeps a beat from being taken on the cycle reset is sampled.
  assign s_axis_video_tready = vid_rstn && accept;
  assign vid_pData           = pdata_q;
  assign vid_pVDE            = vde_q;
  assign vid_pHSync          = hsync_q;
  assign vid_pVSync          = vsync_q;
  assign locked              = locked_q;
  assign underflow           = underflow_q;
  assign sync_err            = sync_err_q;

endmodule

// File: tb/tb_vid_stream_out.sv
// Bench for vid_stream_out on a 15x8 raster: a cycle-level model of the
// display rules checked every cycle, plus hand-computed literal pins.
module tb_vid_stream_out;

  localparam int HA = 8, HT = 15, VA = 4, FT = 120;
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2;

  typedef struct packed {
    logic [23:0] data;
    logic        user;
    logic        last;
  } beat_t;

  logic        PixelClk = 1'b0;
  logic        vidRstn;
  logic [23:0] tdata;
  logic        tvalid, tuser, tlast;
  logic        tready;
  logic [23:0] vidPData;
  logic        vidPVde, vidPHSync, vidPVSync, lockedO, underflowO, syncErrO;

  beat_t       srcQ[$];
  bit          fireSeen = 1'b0;
  bit          stallArmed = 1'b0;
  bit          modelLive = 1'b0;
  int          cyc = 0;
  int          fireTotal = 0;
  int          total = 0;
  int          bad = 0;
  int          mode = M_IDLE;
  logic [23:0] eData;
  logic        eVde, eHs, eVs, eLock, eUf, eSe;

  always #5 PixelClk = ~PixelClk;

  vid_stream_out #(
    .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .H_BACK_PORCH(2),
    .V_ACTIVE(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2), .V_BACK_PORCH(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut (
    .PixelClk           (PixelClk),
    .vid_rstn           (vidRstn),
    .s_axis_video_tdata (tdata),
    .s_axis_video_tvalid(tvalid),
    .s_axis_video_tready(tready),
    .s_axis_video_tuser (tuser),
    .s_axis_video_tlast (tlast),
    .vid_pData          (vidPData),
    .vid_pVDE           (vidPVde),
    .vid_pHSync         (vidPHSync),
    .vid_pVSync         (vidPVSync),
    .locked             (lockedO),
    .underflow          (underflowO),
    .sync_err           (syncErrO)
  );

  task automatic checkOutput(input string name, input logic [23:0] actual, input logic [23:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%h want=%h", name, cyc, actual, expected);
    end
  endtask

  task automatic atCycle(input int n);
    int guard;
    guard = 0;
    @(negedge PixelClk);
    while (cyc != n && guard < 3000) begin
      @(negedge PixelClk);
      guard++;
    end
    if (guard >= 3000) checkOutput("cycleTimeout", 24'(cyc), 24'(n));
  endtask

  task automatic pushFrame(input logic [7:0] tag, input int badLastAt);
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.data = {tag, 8'(i), 8'(i + 8'h40)};
      if (tag == 8'hA0 && i == 0) b.data = 24'h112233;
      b.user = (i == 0);
      b.last = ((i % HA) == HA - 1) || (i == badLastAt);
      srcQ.push_back(b);
    end
  endtask

  task automatic applyStimulus();
    beat_t junk;
    pushFrame(8'hA0, -1);
    pushFrame(8'hB0, 14);
    for (int i = 0; i < 5; i++) begin
      junk.data = {8'h55, 8'(i), 8'hAA};
      junk.user = 1'b0;
      junk.last = 1'b0;
      srcQ.push_back(junk);
    end
    pushFrame(8'hC0, -1);
    pushFrame(8'hD0, -1);
    pushFrame(8'hE0, -1);
  endtask

  always @(posedge PixelClk) cyc <= vidRstn ? cyc + 1 : 0;

  // AXI source: presents the queue head and pops it after a handshake.
  always @(posedge PixelClk) begin
    #1;
    if (fireSeen && srcQ.size() > 0) srcQ.delete(0);
    fireSeen = 1'b0;
    if (stallArmed && (cyc % FT) == 35) begin
      stallArmed = 1'b0;
      tvalid = 1'b0; tdata = '0; tuser = 1'b0; tlast = 1'b0;
    end else if (srcQ.size() > 0) begin
      tvalid = 1'b1; tdata = srcQ[0].data; tuser = srcQ[0].user; tlast = srcQ[0].last;
    end else begin
      tvalid = 1'b0; tdata = '0; tuser = 1'b0; tlast = 1'b0;
    end
  end

  // Model: raster position from the cycle count, display rules applied per cycle.
  always @(negedge PixelClk) begin : compare
    int pos, h, ln;
    bit act;
    logic eTr, nVde, nHs, nVs, nLock, nUf, nSe;
    logic [23:0] nData;
    if (modelLive) begin
      checkOutput("pData", vidPData, eData);
      checkOutput("pVDE", 24'(vidPVde), 24'(eVde));
      checkOutput("pHSync", 24'(vidPHSync), 24'(eHs));
      checkOutput("pVSync", 24'(vidPVSync), 24'(eVs));
      checkOutput("locked", 24'(lockedO), 24'(eLock));
      checkOutput("underflow", 24'(underflowO), 24'(eUf));
      checkOutput("syncErr", 24'(syncErrO), 24'(eSe));
    end
    pos = cyc % FT;
    h = pos % HT;
    ln = pos / HT;
    act = (h < HA) && (ln < VA);
    eTr = 1'b0;
    nData = '0; nVde = act; nLock = 1'b0; nUf = 1'b0; nSe = 1'b0;
    nHs = (h >= 10) && (h < 13);
    nVs = (ln >= 5) && (ln < 7);
    if (!vidRstn) begin
      mode = M_IDLE;
      nVde = 1'b0; nHs = 1'b0; nVs = 1'b0;
      modelLive = 1'b1;
    end else if (mode == M_IDLE) begin
      eTr = act && !(tvalid && tuser);
      if (tvalid && tuser) mode = M_ARMED;
    end else if (mode == M_ARMED) begin
      if (pos == FT - 1) mode = M_RUN;
    end else begin
      nLock = 1'b1;
      if (act) begin
        if (!tvalid) begin
          nUf = 1'b1; nLock = 1'b0; mode = M_IDLE;
        end else if (tuser && pos != 0) begin
          nSe = 1'b1; nLock = 1'b0; mode = M_IDLE;
        end else if (tlast != (h == HA - 1)) begin
          nSe = 1'b1; nLock = 1'b0; eTr = 1'b1; mode = M_IDLE;
        end else begin
          eTr = 1'b1;
          nData = {tdata[23:16], tdata[7:0], tdata[15:8]};
        end
      end
    end
    if (modelLive) checkOutput("tready", 24'(tready), 24'(eTr));
    fireSeen = tvalid && tready;
    if (fireSeen) fireTotal++;
    eData = nData; eVde = nVde; eHs = nHs; eVs = nVs;
    eLock = nLock; eUf = nUf; eSe = nSe;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog cyc=%0d got=running want=finished", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int firesA;
    vidRstn = 1'b0;
    tvalid = 1'b0; tdata = '0; tuser = 1'b0; tlast = 1'b0;
    repeat (3) @(posedge PixelClk);
    #1 vidRstn = 1'b1;
    @(negedge PixelClk);
    checkOutput("relVDE0", 24'(vidPVde), 24'd0);
    checkOutput("relLocked0", 24'(lockedO), 24'd0);
    atCycle(1);
    checkOutput("firstVDE", 24'(vidPVde), 24'd1);
    checkOutput("firstData", vidPData, 24'h0);
    atCycle(9);   checkOutput("blankVDE", 24'(vidPVde), 24'd0);
    atCycle(10);  checkOutput("hsPre", 24'(vidPHSync), 24'd0);
    atCycle(11);  checkOutput("hsStart", 24'(vidPHSync), 24'd1);
    atCycle(13);  checkOutput("hsEnd", 24'(vidPHSync), 24'd1);
    atCycle(14);  checkOutput("hsPost", 24'(vidPHSync), 24'd0);
    atCycle(19);
    checkOutput("drainReady", 24'(tready), 24'd1);
    applyStimulus();
    atCycle(20);  checkOutput("sofHeld", 24'(tready), 24'd0);
    atCycle(30);  checkOutput("armedReady", 24'(tready), 24'd0);
    atCycle(75);  checkOutput("vsPre", 24'(vidPVSync), 24'd0);
    atCycle(76);  checkOutput("vsStart", 24'(vidPVSync), 24'd1);
    atCycle(120); checkOutput("lockPre", 24'(lockedO), 24'd0);
    atCycle(121);
    checkOutput("firstPixel", vidPData, 24'h113322);
    checkOutput("lockRise", 24'(lockedO), 24'd1);
    atCycle(150);
    stallArmed = 1'b1;
    atCycle(155); checkOutput("ufPre", 24'(underflowO), 24'd0);
    atCycle(156);
    checkOutput("ufPulse", 24'(underflowO), 24'd1);
    checkOutput("ufLock", 24'(lockedO), 24'd0);
    checkOutput("ufBlack", vidPData, 24'h0);
    atCycle(157); checkOutput("ufOnce", 24'(underflowO), 24'd0);
    atCycle(381); checkOutput("sePre", 24'(syncErrO), 24'd0);
    atCycle(382);
    checkOutput("sePulse", 24'(syncErrO), 24'd1);
    checkOutput("seLock", 24'(lockedO), 24'd0);
    atCycle(599);
    firesA = fireTotal;
    atCycle(601); checkOutput("afterJunk", vidPData, 24'hC04000);
    atCycle(719); checkOutput("beatsPerFrame", 24'(fireTotal - firesA), 24'd32);
    atCycle(737);
    checkOutput("preRstLock", 24'(lockedO), 24'd1);
    @(posedge PixelClk);
    #1 vidRstn = 1'b0;
    @(negedge PixelClk);
    checkOutput("rstNoAccept", 24'(tready), 24'd0);
    @(posedge PixelClk);
    #1 vidRstn = 1'b1;
    @(negedge PixelClk);
    checkOutput("rstVDE", 24'(vidPVde), 24'd0);
    checkOutput("rstLocked", 24'(lockedO), 24'd0);
    checkOutput("rstData", vidPData, 24'h0);
    atCycle(1);   checkOutput("rstRestart", 24'(vidPVde), 24'd1);
    atCycle(121);
    checkOutput("relockPixel", vidPData, 24'hE04000);
    checkOutput("relock", 24'(lockedO), 24'd1);
    atCycle(230);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
